// File: rtl/pfd_lock_detect_if.sv
// ---------------------------------------------------------------------------
// pfd_lock_detect_if
//
// Signal bundle between the PLL feedback path and the phase-frequency
// detector.  The master side is whatever produces the reference and divided
// feedback clocks (and, when present, clears the slip counter); the slave
// side is the detector itself.
//
// Parameters:
//   ERR_W      width of the signed phase error
//
// Signals:
//   ref_in     reference clock, asynchronous to the detector clock
//   fb_in      divided feedback clock, asynchronous to the detector clock
//   up         charge-pump pump-up request (ref leads fb)
//   dn         charge-pump pump-down request (fb leads ref)
//   phase_err  signed width of the last completed comparison, in clk cycles
//   err_valid  one-cycle strobe marking a phase_err update
//   locked     lock indication
//   slip_clr   (PFD_SLIP_CNT_EN only) synchronous clear of slip_cnt
//   slip_cnt   (PFD_SLIP_CNT_EN only) saturating count of cycle slips
//
// Build option: define PFD_SLIP_CNT_EN to add slip_clr / slip_cnt.
// ---------------------------------------------------------------------------
interface pfd_lock_detect_if #(
    parameter int ERR_W = 8
) ();

    logic                    ref_in;
    logic                    fb_in;
    logic                    up;
    logic                    dn;
    logic signed [ERR_W-1:0] phase_err;
    logic                    err_valid;
    logic                    locked;
`ifdef PFD_SLIP_CNT_EN
    logic                    slip_clr;
    logic [7:0]              slip_cnt;
`endif

`ifdef PFD_SLIP_CNT_EN
    modport master (
        output ref_in, fb_in, slip_clr,
        input  up, dn, phase_err, err_valid, locked, slip_cnt
    );

    modport slave (
        input  ref_in, fb_in, slip_clr,
        output up, dn, phase_err, err_valid, locked, slip_cnt
    );
`else
    modport master (
        output ref_in, fb_in,
        input  up, dn, phase_err, err_valid, locked
    );

    modport slave (
        input  ref_in, fb_in,
        output up, dn, phase_err, err_valid, locked
    );
`endif

endinterface

// File: rtl/pfd_lock_detect.sv
// ---------------------------------------------------------------------------
// pfd_lock_detect
//
// Digital phase-frequency detector with lock detector, placed right after the
// PLL feedback divider.  Both the reference clock and the divided feedback
// clock are oversampled by the fast clock clk.  The detector measures how many
// clk cycles one rising edge leads the other, drives registered UP/DN pulses
// to the charge pump for that long, and reports the signed width of each
// completed comparison.  A lock detector counts consecutive in-tolerance
// comparisons and raises locked after LOCK_CNT of them.
//
// Parameters:
//   ERR_W     width of phase_err (two's complement)
//   LOCK_TOL  largest |phase_err| that counts as in tolerance
//   LOCK_CNT  consecutive in-tolerance comparisons needed for lock (1..255)
//
// Ports:
//   clk       fast sampling clock, rising edge
//   rstn      synchronous reset, ACTIVE HIGH despite the name (1 = reset)
//   bus       pfd_lock_detect_if.slave:
//               ref_in, fb_in           asynchronous clock inputs
//               up, dn                  registered charge-pump requests
//               phase_err, err_valid    comparison result and its strobe
//               locked                  lock flag
//               slip_clr, slip_cnt      only with PFD_SLIP_CNT_EN
//
// Build option: define PFD_SLIP_CNT_EN to add an 8-bit saturating cycle-slip
// counter (slip_cnt) with a synchronous clear input (slip_clr).
// ---------------------------------------------------------------------------
module pfd_lock_detect #(
    parameter int ERR_W    = 8,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 16
) (
    input logic               clk,
    input logic               rstn,
    pfd_lock_detect_if.slave  bus
);

    typedef enum logic [1:0] {
        NEUTRAL = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2
    } state_t;

    // Largest magnitude the width counter may reach: 2^(ERR_W-1)-1, so both
    // +count and -count are representable in phase_err.
    localparam logic [ERR_W-1:0] CNT_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] CNT_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] TOL_VAL  = ERR_W'(LOCK_TOL);
    localparam logic [7:0]       LOCK_VAL = 8'(LOCK_CNT);

    // -----------------------------------------------------------------------
    // Input path: two synchronizer flops plus one history flop per input.
    // Bit 0 is the first synchronizer stage, bit 2 the edge-detect history.
    // -----------------------------------------------------------------------
    logic [2:0] ref_sync;
    logic [2:0] fb_sync;
    logic       ref_edge;
    logic       fb_edge;

    // NOTE: every flop here is an ordinary register with a synchronous
    // clear; there is no storage array, so nothing is left unreset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            ref_sync <= '0;
            fb_sync  <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the value
            // its predecessor held before the edge, which is what turns this
            // into a shift chain rather than a single wire.
            ref_sync <= {ref_sync[1:0], bus.ref_in};
            fb_sync  <= {fb_sync[1:0],  bus.fb_in};
        end
    end

    assign ref_edge = ref_sync[1] & ~ref_sync[2];
    assign fb_edge  = fb_sync[1]  & ~fb_sync[2];

    // -----------------------------------------------------------------------
    // Phase-frequency FSM
    // -----------------------------------------------------------------------
    state_t                  state_q;
    state_t                  state_nxt;
    logic [ERR_W-1:0]        cnt_q;
    logic [ERR_W-1:0]        cnt_nxt;
    logic [ERR_W-1:0]        cnt_inc;
    logic                    up_q;
    logic                    dn_q;
    logic                    err_valid_q;
    logic                    err_valid_nxt;
    logic signed [ERR_W-1:0] phase_err_q;
    logic signed [ERR_W-1:0] phase_err_nxt;
    logic                    slip;

    always_comb begin
        // NOTE: every output of this block gets a default before the case
        // statement, so no path through it can leave a value unassigned and
        // no latch is inferred.
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        err_valid_nxt = 1'b0;
        phase_err_nxt = phase_err_q;
        slip          = 1'b0;
        cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        case (state_q)
            NEUTRAL: begin
                if (ref_edge && fb_edge) begin
                    // Perfectly aligned edges: a zero-width comparison.
                    err_valid_nxt = 1'b1;
                    phase_err_nxt = '0;
                end else if (ref_edge) begin
                    state_nxt = UP;
                    cnt_nxt   = CNT_ONE;
                end else if (fb_edge) begin
                    state_nxt = DOWN;
                    cnt_nxt   = CNT_ONE;
                end
            end

            UP: begin
                if (fb_edge) begin
                    err_valid_nxt = 1'b1;
                    phase_err_nxt = $signed(cnt_q);
                    if (ref_edge) begin
                        // The closing fb edge coincides with the next ref
                        // edge: close this comparison and open the next one.
                        cnt_nxt = CNT_ONE;
                    end else begin
                        state_nxt = NEUTRAL;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    // A second ref edge before any fb edge means fb has
                    // fallen a whole reference period behind.
                    slip    = ref_edge;
                end
            end

            DOWN: begin
                if (ref_edge) begin
                    err_valid_nxt = 1'b1;
                    phase_err_nxt = -$signed(cnt_q);
                    if (fb_edge) begin
                        cnt_nxt = CNT_ONE;
                    end else begin
                        state_nxt = NEUTRAL;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                    slip    = fb_edge;
                end
            end

            default: begin
                state_nxt = NEUTRAL;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= NEUTRAL;
            cnt_q       <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            err_valid_q <= 1'b0;
            phase_err_q <= '0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            // up/dn are decoded from the next state so they change on the
            // same edge as the state register instead of a cycle later.
            up_q        <= (state_nxt == UP);
            dn_q        <= (state_nxt == DOWN);
            err_valid_q <= err_valid_nxt;
            phase_err_q <= phase_err_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Lock detector
    // -----------------------------------------------------------------------
    logic [ERR_W-1:0] abs_err;
    logic             in_tol;
    logic [7:0]       good_q;
    logic [7:0]       good_nxt;
    logic             locked_q;

    // phase_err never reaches the most negative code, so its magnitude
    // always fits in ERR_W bits.
    assign abs_err = phase_err_q[ERR_W-1] ? $unsigned(-phase_err_q)
                                          : $unsigned(phase_err_q);
    assign in_tol  = (abs_err <= TOL_VAL);

    always_comb begin
        good_nxt = good_q;
        if (slip) begin
            good_nxt = '0;
        end else if (err_valid_q) begin
            if (!in_tol) begin
                good_nxt = '0;
            end else if (good_q < LOCK_VAL) begin
                good_nxt = good_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            good_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            good_q   <= good_nxt;
            // Looking at the next count lets locked rise on the cycle right
            // after the qualifying err_valid strobe; because the count
            // saturates, locked then holds until a bad comparison or slip.
            locked_q <= (good_nxt == LOCK_VAL);
        end
    end

    assign bus.up        = up_q;
    assign bus.dn        = dn_q;
    assign bus.err_valid = err_valid_q;
    assign bus.phase_err = phase_err_q;
    assign bus.locked    = locked_q;

    // -----------------------------------------------------------------------
    // Optional cycle-slip counter
    // -----------------------------------------------------------------------
`ifdef PFD_SLIP_CNT_EN
    logic [7:0] slip_cnt_q;

    always_ff @(posedge clk) begin
        if (rstn) begin
            slip_cnt_q <= '0;
        end else if (bus.slip_clr) begin
            slip_cnt_q <= '0;
        end else if (slip && (slip_cnt_q != 8'hFF)) begin
            slip_cnt_q <= slip_cnt_q + 8'd1;
        end
    end

    assign bus.slip_cnt = slip_cnt_q;
`endif

endmodule

// File: tb/tb_pfd_lock_detect.sv
// ---------------------------------------------------------------------------
// tb_pfd_lock_detect
//
// Self-checking bench for pfd_lock_detect.  A table of per-period phase
// offsets with hand-computed results drives the bulk of the checks; reset,
// latency, coincident-edge and saturation corners are written out by hand.
// With PFD_SLIP_CNT_EN defined the slip counter is checked as well.
// ---------------------------------------------------------------------------
module tb_pfd_lock_detect;

    localparam int ERR_W    = 8;
    localparam int LOCK_TOL = 2;
    localparam int LOCK_CNT = 16;
    localparam int P        = 40;   // clk cycles per reference period

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    pfd_lock_detect_if #(.ERR_W(ERR_W)) bus ();

    pfd_lock_detect #(
        .ERR_W   (ERR_W),
        .LOCK_TOL(LOCK_TOL),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int lead;      // >0: ref rises this many cycles before fb
        int exp_err;
        int exp_up;    // cycles up is high in the period
        int exp_dn;    // cycles dn is high in the period
        bit exp_lock;  // locked at the end of the period
    } vec_t;

    vec_t vecs[$];

    // One reference period; ref rises at cycle 10, fb at cycle 10+lead.
    task automatic run_period(input int lead,
                              output int n_valid, output int last_err,
                              output int ev_c, output int n_up,
                              output int n_dn, output int n_both,
                              output int lk_c, output logic lk_end);
        logic lk_prev;
        n_valid = 0; last_err = 0; ev_c = -1; n_up = 0; n_dn = 0;
        n_both = 0; lk_c = -1; lk_prev = 1'b0;
        for (int c = 0; c < P; c++) begin
            @(negedge clk);
            if (bus.err_valid) begin
                n_valid++;
                last_err = int'(bus.phase_err);
                ev_c = c;
            end
            if (bus.up) n_up++;
            if (bus.dn) n_dn++;
            if (bus.up && bus.dn) n_both++;
            if (c > 0 && bus.locked !== lk_prev) lk_c = c;
            lk_prev = bus.locked;
            bus.ref_in = (c >= 10 && c < 30);
            bus.fb_in  = (c >= 10 + lead && c < 30 + lead);
        end
        lk_end = bus.locked;
    endtask

    task automatic wait_valid(input int limit, output bit seen, output int err);
        seen = 1'b0;
        err  = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (bus.err_valid) begin
                seen = 1'b1;
                err  = int'(bus.phase_err);
            end
        end
    endtask

    // Leader rises at 0 and again at 10; the follower rises at 10 (together
    // with the leader) and again at 13.  Expected: +/-10, then +/-3.
    task automatic both_seq(input bit swap);
        int   vals[$];
        int   n_lead_act = 0;
        int   n_other    = 0;
        logic a, b;
        int   sgn = swap ? -1 : 1;
        for (int c = 0; c < P; c++) begin
            @(negedge clk);
            if (bus.err_valid) vals.push_back(int'(bus.phase_err));
            if (swap ? bus.dn : bus.up) n_lead_act++;
            if (swap ? bus.up : bus.dn) n_other++;
            a = (c < 5) || (c >= 10 && c < 25);
            b = (c == 10) || (c >= 13 && c < 25);
            bus.ref_in = swap ? b : a;
            bus.fb_in  = swap ? a : b;
        end
        check($sformatf("both%0d_n_valid", swap), vals.size(), 2);
        if (vals.size() == 2) begin
            check($sformatf("both%0d_err0", swap), vals[0], sgn * 10);
            check($sformatf("both%0d_err1", swap), vals[1], sgn * 3);
        end
        check($sformatf("both%0d_lead_cycles", swap), n_lead_act, 13);
        check($sformatf("both%0d_other_cycles", swap), n_other, 0);
    endtask

    // Leader toggles for n_per periods while the follower stays low, then
    // the follower rises once to close the (saturated) comparison.
    task automatic sat_seq(input bit swap, input int n_per, input int exp_err);
        int   n_valid = 0;
        int   n_other = 0;
        int   n_gap   = 0;
        bit   entered = 1'b0;
        logic lk_after = 1'bx;
        bit   seen;
        int   err;
        logic lead_act, other_act;
        for (int p = 0; p < n_per; p++) begin
            for (int c = 0; c < P; c++) begin
                @(negedge clk);
                lead_act  = swap ? bus.dn : bus.up;
                other_act = swap ? bus.up : bus.dn;
                if (bus.err_valid) n_valid++;
                if (other_act) n_other++;
                if (lead_act) entered = 1'b1;
                else if (entered) n_gap++;
                if (p == 2 && c == 0) lk_after = bus.locked;
                bus.ref_in = swap ? 1'b0 : (c >= 10 && c < 30);
                bus.fb_in  = swap ? (c >= 10 && c < 30) : 1'b0;
            end
        end
        check($sformatf("sat%0d_entered", swap), entered, 1);
        check($sformatf("sat%0d_no_valid", swap), n_valid, 0);
        check($sformatf("sat%0d_other_low", swap), n_other, 0);
        check($sformatf("sat%0d_lead_held", swap), n_gap, 0);
        check($sformatf("sat%0d_lock_after_slip", swap), lk_after, 0);
        if (swap) bus.ref_in = 1'b1;
        else      bus.fb_in  = 1'b1;
        wait_valid(20, seen, err);
        check($sformatf("sat%0d_valid_seen", swap), seen, 1);
        check($sformatf("sat%0d_err", swap), err, exp_err);
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nv, le, evc, nu, nd, nb, lkc;
        logic lke;
        bit   seen;
        int   err;
        int   cnt;

        rstn       = 1'b1;
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
`ifdef PFD_SLIP_CNT_EN
        bus.slip_clr = 1'b0;
`endif

        // ---- reset with toggling inputs ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d_up", i), bus.up, 0);
            check($sformatf("rst%0d_dn", i), bus.dn, 0);
            check($sformatf("rst%0d_valid", i), bus.err_valid, 0);
            check($sformatf("rst%0d_locked", i), bus.locked, 0);
            check($sformatf("rst%0d_err", i), bus.phase_err, 0);
            bus.ref_in = ~bus.ref_in;
            bus.fb_in  = (i == 1);
        end
        @(negedge clk);
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;

        // ---- release and input-to-up latency ----
        @(negedge clk);
        rstn       = 1'b0;
        bus.ref_in = 1'b1;
        @(negedge clk); check("lat_up_1", bus.up, 0);
        @(negedge clk); check("lat_up_2", bus.up, 0);
        @(negedge clk); check("lat_up_3", bus.up, 1);
        bus.fb_in = 1'b1;
        wait_valid(20, seen, err);
        check("lat_valid_seen", seen, 1);
        check("lat_err", err, 3);
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
        repeat (5) @(negedge clk);

        // ---- reset in the middle of a pulse ----
        bus.ref_in = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_up_before", bus.up, 1);
        rstn       = 1'b1;
        bus.ref_in = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.err_valid || bus.up || bus.dn) cnt++;
        end
        check("midrst_quiet", cnt, 0);
        check("midrst_err", bus.phase_err, 0);
        check("midrst_locked", bus.locked, 0);

        // ---- table-driven periods ----
        for (int i = 0; i < 3; i++) vecs.push_back('{5, 5, 5, 0, 1'b0});
        for (int k = 1; k <= 20; k++) vecs.push_back('{-1, -1, 0, 1, (k >= 16)});
        vecs.push_back('{4, 4, 4, 0, 1'b0});
        for (int k = 1; k <= 16; k++) vecs.push_back('{0, 0, 0, 0, (k == 16)});
        vecs.push_back('{2, 2, 2, 0, 1'b1});
        vecs.push_back('{-2, -2, 0, 2, 1'b1});
        vecs.push_back('{3, 3, 3, 0, 1'b0});
        vecs.push_back('{-3, -3, 0, 3, 1'b0});

        foreach (vecs[i]) begin
            run_period(vecs[i].lead, nv, le, evc, nu, nd, nb, lkc, lke);
            check($sformatf("v%0d_n_valid", i), nv, 1);
            check($sformatf("v%0d_err", i), le, vecs[i].exp_err);
            check($sformatf("v%0d_up_cycles", i), nu, vecs[i].exp_up);
            check($sformatf("v%0d_dn_cycles", i), nd, vecs[i].exp_dn);
            check($sformatf("v%0d_up_dn_both", i), nb, 0);
            check($sformatf("v%0d_locked", i), lke, vecs[i].exp_lock);
            if (lkc >= 0) check($sformatf("v%0d_lock_timing", i), lkc, evc + 1);
        end

        // ---- coincident edges while a comparison is open ----
        both_seq(1'b0);
        both_seq(1'b1);

        // ---- re-lock, then saturation and cycle slips ----
        for (int k = 0; k < LOCK_CNT; k++) begin
            run_period(0, nv, le, evc, nu, nd, nb, lkc, lke);
        end
        check("relock_locked", lke, 1);
        sat_seq(1'b0, 200, 127);
        sat_seq(1'b1, 5, -127);
        check("sat_end_locked", bus.locked, 0);

`ifdef PFD_SLIP_CNT_EN
        // 199 slips from the positive run plus 4 from the negative run.
        check("slip_accum", bus.slip_cnt, 203);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("slip_rst", bus.slip_cnt, 0);
        rstn = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < P; c++) begin
                @(negedge clk);
                bus.ref_in = (c >= 10 && c < 30);
            end
        end
        check("slip_cnt_3edges", bus.slip_cnt, 2);
        bus.slip_clr = 1'b1;
        @(negedge clk);
        bus.slip_clr = 1'b0;
        check("slip_clr", bus.slip_cnt, 0);
        bus.fb_in = 1'b1;
        wait_valid(20, seen, err);
        bus.fb_in = 1'b0;
        repeat (5) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfd_lock_detect.md
Name:
pfd_lock_detect

Overview:
- Digital phase-frequency detector with lock detector.
- Sits directly downstream of the PLL feedback frequency divider: it compares the divided feedback clock against the reference clock.
- Drives UP/DN correction pulses to the charge-pump/loop-filter stage and reports a signed phase error plus a lock flag.
- Both inputs are oversampled by a single fast clock (clk).

Parameters:
- ERR_W, 8: width of the signed phase_err output, two's complement.
- LOCK_TOL, 2: maximum |phase_err|, in clk cycles, that counts as in-tolerance.
- LOCK_CNT, 16: number of consecutive in-tolerance comparisons required to assert locked (1..255).

Ports:
- clk  input  1  fast sampling clock; all logic is on its rising edge.
- rstn  input  1  synchronous, active-high reset (1 = reset).
- ref_in  input  1  reference clock; asynchronous to clk.
- fb_in  input  1  divided feedback clock (divider output bit); asynchronous to clk.
- up  output  1  registered; high while ref leads fb.
- dn  output  1  registered; high while fb leads ref.
- phase_err  output  ERR_W  signed pulse width of the last comparison, in clk cycles.
- err_valid  output  1  one-cycle strobe; phase_err is updated on this cycle.
- locked  output  1  lock indication.

Behaviour:
- Reset: rstn=1 sampled at a rising clk edge clears everything.
  - Cleared: up=0, dn=0, phase_err=0, err_valid=0, locked=0, state=NEUTRAL, all counters=0, synchronizer flops=0.
  - Reset mid-pulse discards the pulse in progress; no err_valid is produced for it.
- Input path:
  - ref_in and fb_in each pass through a 2-flop synchronizer, then a third flop for rising-edge detect.
  - ref_edge = s2 & ~s3; fb_edge is formed the same way.
  - Latency: up/dn assert on the 3rd rising clk edge after the input is first sampled high.
- FSM states: NEUTRAL, UP, DOWN. up=1 only in UP; dn=1 only in DOWN; up and dn are never both high.
- NEUTRAL:
  - ref_edge only -> UP, width counter := 1.
  - fb_edge only -> DOWN, width counter := 1.
  - Both edges in the same cycle -> stay NEUTRAL; err_valid=1, phase_err=0.
- UP:
  - Each cycle with no fb_edge: counter increments, saturating at 2^(ERR_W-1)-1.
  - fb_edge -> NEUTRAL; err_valid=1, phase_err=+counter.
  - ref_edge without fb_edge = cycle slip: stay UP, counter keeps running, locked cleared.
  - ref_edge and fb_edge in the same cycle: err_valid=1, phase_err=+counter, stay UP, counter := 1.
- DOWN: mirror image of UP.
  - phase_err = -counter.
  - fb_edge without ref_edge = slip.
  - Negative saturation at -(2^(ERR_W-1)-1).
- err_valid is registered and asserts the cycle after the terminating edge is detected. phase_err holds its value until the next err_valid.
- Lock detector (good counter, 8 bits):
  - On err_valid with |phase_err| <= LOCK_TOL: good counter increments, saturating at LOCK_CNT.
  - When the good counter reaches LOCK_CNT, locked=1 on the following cycle.
  - On err_valid with |phase_err| > LOCK_TOL, or on any slip: good counter := 0 and locked := 0 on the next cycle.
  - locked stays high otherwise.
- Wrap-around: the width counter never wraps (it saturates). The good counter never wraps (it saturates).

Optional Feature:
- Macro: PFD_SLIP_CNT_EN.
- When defined:
  - Adds output slip_cnt (8 bits), reset to 0.
  - slip_cnt increments once per slip event and saturates at 255.
  - Adds input slip_clr (1 bit): a synchronous clear, taking priority over increment in the same cycle.
- When undefined: neither port exists, no slip counter logic is present, and all other behaviour is identical.

Test Plan:
- Reset: hold rstn=1 for 3 cycles with ref_in/fb_in toggling -> up=dn=err_valid=locked=0, phase_err=0 throughout; first outputs appear no earlier than 3 cycles after release.
- Ref leads: ref_in rises 5 clk cycles before fb_in, repeated -> up high exactly 5 cycles, err_valid once per period, phase_err=+5, dn never high, locked stays 0 (5 > LOCK_TOL).
- Fb leads by 1, LOCK_CNT=16: 20 periods with fb_in rising 1 cycle early -> phase_err=-1 each period; locked rises the cycle after the 16th err_valid.
- Lock loss: after lock, one period with a 4-cycle lead -> phase_err=+4; locked drops to 0 the next cycle; 16 further good periods are required to re-lock.
- Simultaneous and saturation: ref_in and fb_in rise in the same sample -> err_valid with phase_err=0 and no up/dn; fb_in held low for 200 ref periods with ERR_W=8 -> cycle slips clear locked, up stays high, counter saturates at +127.
- PFD_SLIP_CNT_EN defined: 3 ref edges with no fb edge -> slip_cnt=2; then slip_clr=1 for 1 cycle -> slip_cnt=0.
